// File: rtl/pipeline_step_tracer.sv
// Single-step debug controller for the five-stage core: gates the core's halt
// and streams a framed snapshot of the six stage-visualisation words per step.
module pipeline_step_tracer #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_mode,
  input  logic        step_req,
  input  logic [31:0] outFE,
  input  logic [31:0] DecoVisu,
  input  logic [31:0] ExeVisu,
  input  logic [31:0] MemVisu,
  input  logic [31:0] MemPixVisu,
  input  logic [31:0] WBVisu,
  output logic        halt,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  step_cnt
);

  localparam logic [2:0] S_HALTED  = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_SEND    = 3'd5;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);
  localparam logic [4:0] LAST_IDX    = 5'd25;

  logic [2:0]   state_q, state_d;
  logic [3:0]   settle_q, settle_d;
  logic [4:0]   idx_q, idx_d;
  logic [199:0] snap_q, snap_d;
  logic         halt_q, halt_d;
  logic         busy_q, busy_d;
  logic         tx_valid_q, tx_valid_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic [7:0]   step_cnt_q, step_cnt_d;

  // Frame byte idx: byte 0 is the header, the rest walk the snapshot MSB first.
  function automatic logic [7:0] frame_byte(input logic [199:0] snap, input logic [4:0] idx);
    logic [207:0] frame;
    logic [7:0]   lo;
    frame = {HEADER, snap};
    lo    = {LAST_IDX - idx, 3'b000};
    return frame[lo +: 8];
  endfunction

  // Next-state, snapshot and output-register computation.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      S_HALTED: begin
        if (!step_mode) begin
          state_d = S_RUN;
        end else if (step_req) begin
          state_d = S_STEP;
        end else begin
          state_d = S_HALTED;
        end
      end
      S_RUN: begin
        if (step_mode) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        step_cnt_d = step_cnt_q + 8'd1;
        settle_d   = SETTLE_INIT;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_CAPTURE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        snap_d     = {step_cnt_q, outFE, DecoVisu, ExeVisu, MemVisu, MemPixVisu, WBVisu};
        idx_d      = 5'd0;
        tx_valid_d = 1'b1;
        tx_data_d  = HEADER;
        state_d    = S_SEND;
      end
      S_SEND: begin
        // Next byte is preloaded from the frozen snapshot on each acceptance.
        if (tx_valid_q && tx_ready) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            state_d    = S_HALTED;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_data_d = frame_byte(snap_q, idx_q + 5'd1);
          end
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_HALTED;
      end
    endcase
    halt_d = !((state_d == S_RUN) || (state_d == S_STEP));
    busy_d = (state_d == S_STEP) || (state_d == S_SETTLE) ||
             (state_d == S_CAPTURE) || (state_d == S_SEND);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HALTED;
      settle_q   <= 4'd0;
      idx_q      <= 5'd0;
      snap_q     <= 200'd0;
      halt_q     <= 1'b1;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      step_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      halt_q     <= halt_d;
      busy_q     <= busy_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign halt     = halt_q;
  assign busy     = busy_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_pipeline_step_tracer.sv
// Directed self-checking bench for pipeline_step_tracer (SETTLE_CYC=2, HEADER=A5).
module tb_pipeline_step_tracer;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_mode;
  logic        step_req;
  logic [31:0] stg [6];
  logic        halt;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  step_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_b [26];
  logic [7:0] got [$];

  pipeline_step_tracer #(.SETTLE_CYC(2), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .step_mode(step_mode), .step_req(step_req),
    .outFE(stg[0]), .DecoVisu(stg[1]), .ExeVisu(stg[2]), .MemVisu(stg[3]),
    .MemPixVisu(stg[4]), .WBVisu(stg[5]),
    .halt(halt), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame from the current stage inputs and the step count.
  task automatic build_exp(input logic [7:0] cnt);
    exp_b[0] = 8'hA5;
    exp_b[1] = cnt;
    for (int w = 0; w < 6; w++)
      for (int b = 0; b < 4; b++)
        exp_b[2 + 4*w + b] = stg[w][31 - 8*b -: 8];
  endtask

  task automatic set_stg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] e, input logic [31:0] f);
    stg[0] = a; stg[1] = b; stg[2] = c; stg[3] = d; stg[4] = e; stg[5] = f;
  endtask

  // Issue one step from HALTED and collect accepted bytes until busy clears.
  task automatic run_step(input bit toggle, input bit pulse_settle, input bit pulse_send,
                          input bit scramble, input bit drop_mode, input int stop_after,
                          output bit done, output bit hold_ok);
    logic pv, pr;
    logic [7:0] pd;
    got.delete();
    done = 1'b0; hold_ok = 1'b1; pv = 1'b0; pr = 1'b1; pd = 8'h00;
    step_req = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) hold_ok = 1'b0;
      if (!busy) begin
        step_req = 1'b0;
        done = 1'b1;
        break;
      end
      step_req = 1'b0;
      if (pulse_settle && c == 1) step_req = 1'b1;
      if (drop_mode) step_mode = 1'b0;
      if (tx_valid) begin
        if (pulse_send) step_req = (c % 2 == 0);
        if (scramble)
          for (int i = 0; i < 6; i++) stg[i] = $urandom();
      end
      tx_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (got.size() == stop_after) begin
          done = 1'b1;
          break;
        end
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    step_req = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; step_mode = 1'b1; step_req = 1'b0; tx_ready = 1'b1;
    set_stg(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL reset_halt got %b exp 1", halt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", tx_data); end
    checks++; if (step_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", step_cnt); end
    reset = 1'b0;
    tick();
    checks++; if (halt !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_halted halt %b busy %b exp 1 0", halt, busy); end
  endtask

  task automatic test_single_step();
    set_stg(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h0F1E2D3C, 32'h4B5A6978);
    build_exp(8'd1);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks++; if (halt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL step_c1 halt %b busy %b exp 0 1", halt, busy); end
    tick();
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL step_c2_halt got %b exp 1", halt); end
    tick(); tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL step_c4_valid got %b exp 0", tx_valid); end
    for (int cyc = 5; cyc <= 30; cyc++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[cyc-5]) begin
        errors++;
        $display("FAIL step_byte%0d valid %b data %h exp 1 %h", cyc-5, tx_valid, tx_data, exp_b[cyc-5]);
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || halt !== 1'b1) begin
      errors++; $display("FAIL step_c31 busy %b valid %b halt %b exp 0 0 1", busy, tx_valid, halt); end
    checks++; if (step_cnt !== 8'd1) begin errors++; $display("FAIL step_cnt got %0d exp 1", step_cnt); end
  endtask

  task automatic test_ready_toggle();
    bit done, hold_ok;
    set_stg(32'hA1B2C3D4, 32'h01020304, 32'hCAFEBABE, 32'hDEADBEEF, 32'h13579BDF, 32'h2468ACE0);
    build_exp(8'd2);
    run_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 99, done, hold_ok);
    checks++; if (!done) begin errors++; $display("FAIL toggle_done got 0 exp 1"); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL toggle_hold got unstable exp stable"); end
    checks++; if (got.size() != 26) begin errors++; $display("FAIL toggle_len got %0d exp 26", got.size()); end
    for (int i = 0; i < 26; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_b[i]) begin
        errors++; $display("FAIL toggle_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++; if (step_cnt !== 8'd2) begin errors++; $display("FAIL toggle_cnt got %0d exp 2", step_cnt); end
  endtask

  task automatic test_drop_requests();
    bit done, hold_ok;
    int extra;
    set_stg(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005, 32'h00000006);
    build_exp(8'd3);
    run_step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 99, done, hold_ok);
    checks++; if (!done || got.size() != 26) begin errors++; $display("FAIL drop_len got %0d exp 26", got.size()); end
    checks++; if (got.size() > 1 && got[1] !== 8'd3) begin errors++; $display("FAIL drop_byte1 got %h exp 03", got[1]); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0 || tx_valid !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL drop_second_frame got %0d busy cycles exp 0", extra); end
    checks++; if (step_cnt !== 8'd3) begin errors++; $display("FAIL drop_cnt got %0d exp 3", step_cnt); end
  endtask

  task automatic test_input_freeze();
    bit done, hold_ok;
    int bad;
    set_stg(32'hFEDCBA98, 32'h76543210, 32'h0BADF00D, 32'h8BADF00D, 32'hC001D00D, 32'hFACEFEED);
    build_exp(8'd4);
    run_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 99, done, hold_ok);
    checks++; if (!done || got.size() != 26) begin errors++; $display("FAIL freeze_len got %0d exp 26", got.size()); end
    bad = 0;
    for (int i = 0; i < 26; i++)
      if (i >= got.size() || got[i] !== exp_b[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL freeze_bytes got %0d wrong bytes exp 0", bad); end
  endtask

  task automatic test_free_run();
    step_mode = 1'b0;
    tick();
    checks++; if (halt !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL run_entry halt %b busy %b exp 0 0", halt, busy); end
    step_req = 1'b1;
    tick(); tick(); tick();
    step_req = 1'b0;
    checks++; if (halt !== 1'b0 || step_cnt !== 8'd4) begin errors++; $display("FAIL run_ignore halt %b cnt %0d exp 0 4", halt, step_cnt); end
    step_mode = 1'b1;
    tick();
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL run_exit got %b exp 1", halt); end
    tick();
    checks++; if (busy !== 1'b0 || halt !== 1'b1) begin errors++; $display("FAIL run_halted busy %b halt %b exp 0 1", busy, halt); end
  endtask

  task automatic test_mode_drop_mid_frame();
    bit done, hold_ok;
    int bad;
    set_stg(32'h31415926, 32'h27182818, 32'h16180339, 32'h14142135, 32'h17320508, 32'h22360679);
    build_exp(8'd5);
    run_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 99, done, hold_ok);
    bad = 0;
    for (int i = 0; i < 26; i++)
      if (i >= got.size() || got[i] !== exp_b[i]) bad++;
    checks++; if (!done || got.size() != 26 || bad != 0) begin
      errors++; $display("FAIL modedrop_frame got %0d bytes %0d wrong exp 26 0", got.size(), bad); end
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL modedrop_halted got %b exp 1", halt); end
    tick();
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL modedrop_run got %b exp 0", halt); end
    step_mode = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    bit done, hold_ok;
    int leaks;
    set_stg(32'h01234567, 32'h89ABCDEF, 32'h02468ACE, 32'h13579BDF, 32'hAAAA5555, 32'h5555AAAA);
    run_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, done, hold_ok);
    checks++; if (got.size() != 10 || tx_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup got %0d bytes valid %b exp 10 1", got.size(), tx_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (tx_valid !== 1'b0 || halt !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs valid %b halt %b busy %b exp 0 1 0", tx_valid, halt, busy); end
    checks++; if (step_cnt !== 8'd0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_cnt cnt %0d data %h exp 0 00", step_cnt, tx_data); end
    leaks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_valid !== 1'b0) leaks++;
    end
    checks++; if (leaks != 0) begin errors++; $display("FAIL rst_mid_tail got %0d valid cycles exp 0", leaks); end
  endtask

  task automatic test_wrap();
    bit done, hold_ok;
    int bad_runs;
    set_stg(32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000, 32'h0A0B0C0D, 32'h0E0F1011);
    bad_runs = 0;
    for (int s = 1; s <= 254; s++) begin
      run_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 99, done, hold_ok);
      if (!done || got.size() != 26) bad_runs++;
    end
    checks++; if (bad_runs != 0) begin errors++; $display("FAIL wrap_runs got %0d bad frames exp 0", bad_runs); end
    run_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 99, done, hold_ok);
    checks++; if (got.size() < 2 || got[1] !== 8'hFF) begin errors++; $display("FAIL wrap_255 got %h exp ff", (got.size() > 1) ? got[1] : 8'hxx); end
    build_exp(8'h00);
    run_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 99, done, hold_ok);
    checks++; if (got.size() < 2 || got[1] !== 8'h00) begin errors++; $display("FAIL wrap_256 got %h exp 00", (got.size() > 1) ? got[1] : 8'hxx); end
    checks++; if (got.size() != 26 || got[25] !== exp_b[25]) begin errors++; $display("FAIL wrap_frame got %0d bytes exp 26", got.size()); end
    checks++; if (step_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got %0d exp 0", step_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_ready_toggle();
    test_drop_requests();
    test_input_freeze();
    test_free_run();
    test_mode_drop_mid_frame();
    test_reset_mid_frame();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
